floo_output_scheduler: RTL and testbench
========================================

FLOO_OUTPUT_SCHEDULER -- requirements
Module: floo_output_scheduler

Interface
REQ-001 SHALL have parameter flit_t, default logic; flit payload type, passed through unmodified.
REQ-002 SHALL have parameter StarveThresh, default 8; reduction flits a waiting unicast tolerates before forced grant, legal range 1..255.
REQ-003 SHALL have parameter CntWidth, default 8; starvation counter width, StarveThresh < 2**CntWidth.
REQ-004 SHALL have ports: clk_i input 1 clock; rst_ni input 1 asynchronous active-low reset; one clock, all state on rising edge.
REQ-005 SHALL have ports: red_valid_i input 1; red_ready_o output 1; red_data_i input flit_t; red_last_i input 1, marks final flit of reduction packet.
REQ-006 SHALL have ports: uni_valid_i input 1; uni_ready_o output 1; uni_data_i input flit_t; uni_last_i input 1, marks final flit of unicast packet.
REQ-007 SHALL have ports: valid_o output 1; ready_i input 1; data_o output flit_t; merged output stream.
REQ-008 SHALL have ports: sel_red_o output 1, current output source is reduction; starved_o output 1, forced-unicast condition active.
REQ-009 SHALL have ports: red_flits_o output 16, uni_flits_o output 16; flit statistics (see Configuration).

Function
REQ-010 SHALL implement FSM states IDLE, RED_LOCK, UNI_LOCK.
REQ-011 IDLE: source chosen combinationally per cycle; reduction wins unless starved_o=1 and uni_valid_i=1; if only one valid, that one is chosen.
REQ-012 Transfer = valid_o & ready_i; on transfer of non-last flit in IDLE, SHALL move to lock state of chosen source.
REQ-013 RED_LOCK/UNI_LOCK: only locked source is forwarded, other ready held 0 regardless of priority or starvation; transfer with last=1 returns to IDLE.
REQ-014 Single-flit packets (last=1 on first transfer) SHALL keep FSM in IDLE.
REQ-015 Datapath zero latency: data_o/valid_o mux of selected input; selected ready = ready_i; unselected ready = 0.
REQ-016 valid_o SHALL NOT depend on ready_i; selection SHALL NOT change while valid_o=1 and ready_i=0 (stable under backpressure, AXI-stream rule).
REQ-017 Starvation counter: +1 per reduction-flit transfer while uni_valid_i=1; cleared on any unicast-flit transfer; saturates at StarveThresh.
REQ-018 starved_o SHALL be 1 iff counter == StarveThresh.
REQ-019 Forced grant SHALL take effect only at packet boundary (IDLE); an in-flight reduction packet completes first.
REQ-020 sel_red_o SHALL be 1 when selected source is reduction (IDLE choice or RED_LOCK), else 0; in IDLE with no valid input sel_red_o=0.
REQ-021 Simultaneous red_valid_i and uni_valid_i with counter below threshold: reduction granted.
REQ-022 Input valid dropped mid-packet in lock state: valid_o=0, lock retained, no switch.

Reset
REQ-023 On rst_ni low, asynchronously: FSM=IDLE, counter=0, statistics=0.
REQ-024 During reset outputs SHALL be: valid_o=0, red_ready_o=0, uni_ready_o=0, sel_red_o=0, starved_o=0, red_flits_o=0, uni_flits_o=0.
REQ-025 Reset asserted mid-packet SHALL discard lock; after release, arbitration restarts in IDLE with no memory of partial packet.

Configuration
REQ-026 Macro FLOO_OUTPUT_SCHED_STATS_EN SHALL control statistics counters.
REQ-027 Defined: red_flits_o/uni_flits_o count transferred flits per source, 16-bit, saturating at 16'hFFFF.
REQ-028 Undefined: no counter flops; red_flits_o and uni_flits_o tied to 0; all other behaviour identical.

Verification
REQ-029 Both valid, single-flit packets, ready_i=1, StarveThresh=8 -> 8 reduction flits, starved_o=1, next grant unicast, counter back to 0.
REQ-030 Reduction 4-flit packet in progress when starved_o rises -> all 4 reduction flits complete, then unicast granted.
REQ-031 Unicast 3-flit packet locked, red_valid_i asserted at flit 2 -> uni_ready_o stays 1, red_ready_o=0 until uni_last_i transfer.
REQ-032 ready_i=0 for 5 cycles with both valid -> data_o and sel_red_o stable, no counter change, no stat increment.
REQ-033 rst_ni pulsed low mid unicast packet -> all outputs 0 immediately, FSM IDLE after release, reduction granted first.
REQ-034 With FLOO_OUTPUT_SCHED_STATS_EN: 70000 reduction flits -> red_flits_o=16'hFFFF; without macro -> 0.

Source files
------------

// File: rtl/floo_output_scheduler.sv
// floo_output_scheduler
// Merges a reduction stream and a unicast stream onto one output link.
// Arbitration happens on packet boundaries only. Reduction normally has
// priority. A starvation counter forces a unicast grant after StarveThresh
// reduction flits have overtaken a waiting unicast.
// Optional feature macro: FLOO_OUTPUT_SCHED_STATS_EN adds per-source
// saturating flit counters. When it is undefined, those outputs read zero.
module floo_output_scheduler #(
    parameter type         flit_t       = logic,
    parameter int unsigned StarveThresh = 8,
    parameter int unsigned CntWidth     = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        red_valid_i,
    output logic        red_ready_o,
    input  flit_t       red_data_i,
    input  logic        red_last_i,
    input  logic        uni_valid_i,
    output logic        uni_ready_o,
    input  flit_t       uni_data_i,
    input  logic        uni_last_i,
    output logic        valid_o,
    input  logic        ready_i,
    output flit_t       data_o,
    output logic        sel_red_o,
    output logic        starved_o,
    output logic [15:0] red_flits_o,
    output logic [15:0] uni_flits_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RED_LOCK = 2'd1,
        UNI_LOCK = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] THRESH_C = CntWidth'(StarveThresh);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [CntWidth-1:0] starve_cnt_r;
    // Remembers an IDLE-state offer that stalled, so a starvation change or
    // a late-arriving competitor cannot swap the source under backpressure.
    logic                hold_r;
    logic                hold_red_r;
    logic                sel_red_s;
    logic                sel_uni_s;
    logic                valid_s;
    logic                last_s;
    logic                xfer_s;
    logic                starved_s;

    assign starved_s = (starve_cnt_r == THRESH_C);

    // Source selection: lock states pin the source, IDLE arbitrates per cycle
    always_comb begin
        sel_red_s = 1'b0;
        sel_uni_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (hold_r && hold_red_r && red_valid_i) begin
                    sel_red_s = 1'b1;
                end else if (hold_r && !hold_red_r && uni_valid_i) begin
                    sel_uni_s = 1'b1;
                end else if (red_valid_i && !(starved_s && uni_valid_i)) begin
                    sel_red_s = 1'b1;
                end else if (uni_valid_i) begin
                    sel_uni_s = 1'b1;
                end else begin
                    sel_red_s = 1'b0;
                    sel_uni_s = 1'b0;
                end
            end
            RED_LOCK: sel_red_s = 1'b1;
            UNI_LOCK: sel_uni_s = 1'b1;
            default: begin
                sel_red_s = 1'b0;
                sel_uni_s = 1'b0;
            end
        endcase
    end

    // Zero-latency output mux. Reset forces every handshake output low.
    always_comb begin
        valid_s     = 1'b0;
        last_s      = 1'b0;
        data_o      = red_data_i;
        if (sel_red_s) begin
            valid_s = red_valid_i;
            last_s  = red_last_i;
            data_o  = red_data_i;
        end else if (sel_uni_s) begin
            valid_s = uni_valid_i;
            last_s  = uni_last_i;
            data_o  = uni_data_i;
        end else begin
            valid_s = 1'b0;
            last_s  = 1'b0;
            data_o  = uni_data_i;
        end
    end

    assign valid_o     = rst_ni & valid_s;
    assign xfer_s      = valid_o & ready_i;
    assign red_ready_o = rst_ni & sel_red_s & ready_i;
    assign uni_ready_o = rst_ni & sel_uni_s & ready_i;
    assign sel_red_o   = rst_ni & sel_red_s;
    assign starved_o   = rst_ni & starved_s;

    // Next-state logic: lock on a non-last transfer, release on last transfer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && !last_s && sel_red_s) begin
                    state_nxt_s = RED_LOCK;
                end else if (xfer_s && !last_s && sel_uni_s) begin
                    state_nxt_s = UNI_LOCK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RED_LOCK, UNI_LOCK: begin
                if (xfer_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus the stalled-offer memory used in IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            hold_r     <= 1'b0;
            hold_red_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_r     <= (state_r == IDLE) && valid_s && !ready_i;
            hold_red_r <= sel_red_s;
        end
    end

    // Starvation counter: reduction flits that overtook a waiting unicast
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_r <= '0;
        end else if (xfer_s && sel_uni_s) begin
            starve_cnt_r <= '0;
        end else if (xfer_s && sel_red_s && uni_valid_i && !starved_s) begin
            starve_cnt_r <= starve_cnt_r + {{(CntWidth-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

`ifdef FLOO_OUTPUT_SCHED_STATS_EN
    logic [15:0] red_flits_r;
    logic [15:0] uni_flits_r;

    // Per-source transferred-flit counters, saturating at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            red_flits_r <= 16'd0;
            uni_flits_r <= 16'd0;
        end else begin
            if (xfer_s && sel_red_s && (red_flits_r != 16'hFFFF)) begin
                red_flits_r <= red_flits_r + 16'd1;
            end else begin
                red_flits_r <= red_flits_r;
            end
            if (xfer_s && sel_uni_s && (uni_flits_r != 16'hFFFF)) begin
                uni_flits_r <= uni_flits_r + 16'd1;
            end else begin
                uni_flits_r <= uni_flits_r;
            end
        end
    end

    assign red_flits_o = red_flits_r;
    assign uni_flits_o = uni_flits_r;
`else
    assign red_flits_o = 16'd0;
    assign uni_flits_o = 16'd0;
`endif

endmodule

// File: tb/tb_floo_output_scheduler.sv
// Directed testbench for floo_output_scheduler (StarveThresh = 8, 8-bit flits).
// Statistics expectations follow FLOO_OUTPUT_SCHED_STATS_EN when defined.
module tb_floo_output_scheduler;

    logic        clk;
    logic        rst_ni;
    logic        red_valid_i, red_ready_o, red_last_i;
    logic [7:0]  red_data_i;
    logic        uni_valid_i, uni_ready_o, uni_last_i;
    logic [7:0]  uni_data_i;
    logic        valid_o, ready_i;
    logic [7:0]  data_o;
    logic        sel_red_o, starved_o;
    logic [15:0] red_flits_o, uni_flits_o;

    int n_tests = 0;
    int n_fail  = 0;

    floo_output_scheduler #(
        .flit_t      (logic [7:0]),
        .StarveThresh(8),
        .CntWidth    (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .red_valid_i(red_valid_i),
        .red_ready_o(red_ready_o),
        .red_data_i (red_data_i),
        .red_last_i (red_last_i),
        .uni_valid_i(uni_valid_i),
        .uni_ready_o(uni_ready_o),
        .uni_data_i (uni_data_i),
        .uni_last_i (uni_last_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .sel_red_o  (sel_red_o),
        .starved_o  (starved_o),
        .red_flits_o(red_flits_o),
        .uni_flits_o(uni_flits_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] es(input logic [31:0] v);
`ifdef FLOO_OUTPUT_SCHED_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        red_valid_i = 1'b1; red_last_i = 1'b1; red_data_i = 8'hA0;
        uni_valid_i = 1'b1; uni_last_i = 1'b1; uni_data_i = 8'h5B;
        ready_i     = 1'b1;
        #1;
        // Reset state with both inputs offering
        chk("rst_valid",     32'(valid_o),     32'd0);
        chk("rst_red_ready", 32'(red_ready_o), 32'd0);
        chk("rst_uni_ready", 32'(uni_ready_o), 32'd0);
        chk("rst_sel_red",   32'(sel_red_o),   32'd0);
        chk("rst_starved",   32'(starved_o),   32'd0);
        chk("rst_red_flits", 32'(red_flits_o), 32'd0);
        chk("rst_uni_flits", 32'(uni_flits_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        #1;

        // Single-flit packets, both valid: 8 reduction grants, then unicast
        for (int i = 0; i < 8; i++) begin
            red_data_i = 8'hA0 + 8'(i);
            #1;
            chk("sf_sel_red", 32'(sel_red_o), 32'd1);
            chk("sf_data",    32'(data_o),    32'(8'hA0 + 8'(i)));
            chk("sf_starved", 32'(starved_o), 32'd0);
            tick();
        end
        chk("thr_starved",   32'(starved_o),   32'd1);
        chk("thr_sel_red",   32'(sel_red_o),   32'd0);
        chk("thr_uni_ready", 32'(uni_ready_o), 32'd1);
        chk("thr_red_ready", 32'(red_ready_o), 32'd0);
        chk("thr_data",      32'(data_o),      32'h5B);
        tick();
        chk("clr_starved", 32'(starved_o), 32'd0);
        chk("clr_sel_red", 32'(sel_red_o), 32'd1);
        chk("st1_red",     32'(red_flits_o), es(32'd8));
        chk("st1_uni",     32'(uni_flits_o), es(32'd1));

        // Six single reduction flits, then a 4-flit packet crossing threshold
        repeat (6) tick();
        red_last_i = 1'b0;
        #1;
        tick();
        tick();
        chk("mp_starved",   32'(starved_o),   32'd1);
        chk("mp_sel_red",   32'(sel_red_o),   32'd1);
        chk("mp_uni_ready", 32'(uni_ready_o), 32'd0);
        chk("mp_red_ready", 32'(red_ready_o), 32'd1);
        tick();
        red_last_i = 1'b1;
        #1;
        chk("mp4_sel_red", 32'(sel_red_o), 32'd1);
        tick();
        chk("mpe_sel_red",   32'(sel_red_o),   32'd0);
        chk("mpe_uni_ready", 32'(uni_ready_o), 32'd1);
        chk("mpe_red_ready", 32'(red_ready_o), 32'd0);

        // 3-flit unicast packet locked while reduction keeps requesting
        uni_last_i = 1'b0;
        #1;
        tick();
        chk("ul_starved",   32'(starved_o),   32'd0);
        chk("ul_sel_red",   32'(sel_red_o),   32'd0);
        chk("ul_uni_ready", 32'(uni_ready_o), 32'd1);
        chk("ul_red_ready", 32'(red_ready_o), 32'd0);
        uni_valid_i = 1'b0;
        #1;
        chk("drop_valid",     32'(valid_o),     32'd0);
        chk("drop_red_ready", 32'(red_ready_o), 32'd0);
        chk("drop_sel_red",   32'(sel_red_o),   32'd0);
        tick();
        uni_valid_i = 1'b1;
        #1;
        tick();
        uni_last_i = 1'b1;
        #1;
        chk("ul3_uni_ready", 32'(uni_ready_o), 32'd1);
        chk("ul3_red_ready", 32'(red_ready_o), 32'd0);
        tick();
        chk("ule_sel_red",   32'(sel_red_o),   32'd1);
        chk("ule_red_ready", 32'(red_ready_o), 32'd1);
        chk("ule_uni_ready", 32'(uni_ready_o), 32'd0);
        chk("st2_red",       32'(red_flits_o), es(32'd18));
        chk("st2_uni",       32'(uni_flits_o), es(32'd4));

        // Backpressure for 5 cycles with both valid
        ready_i    = 1'b0;
        red_data_i = 8'hC3;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",     32'(valid_o),     32'd1);
            chk("bp_data",      32'(data_o),      32'hC3);
            chk("bp_sel_red",   32'(sel_red_o),   32'd1);
            chk("bp_red_ready", 32'(red_ready_o), 32'd0);
            tick();
        end
        chk("bp_starved", 32'(starved_o),   32'd0);
        chk("bp_red_st",  32'(red_flits_o), es(32'd18));
        chk("bp_uni_st",  32'(uni_flits_o), es(32'd4));

        // Reset pulse in the middle of a unicast packet
        ready_i     = 1'b1;
        red_valid_i = 1'b0;
        uni_last_i  = 1'b0;
        #1;
        tick();
        red_valid_i = 1'b1;
        #1;
        chk("pre_rst_sel_red", 32'(sel_red_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("mrst_valid",     32'(valid_o),     32'd0);
        chk("mrst_red_ready", 32'(red_ready_o), 32'd0);
        chk("mrst_uni_ready", 32'(uni_ready_o), 32'd0);
        chk("mrst_sel_red",   32'(sel_red_o),   32'd0);
        chk("mrst_starved",   32'(starved_o),   32'd0);
        chk("mrst_red_st",    32'(red_flits_o), 32'd0);
        chk("mrst_uni_st",    32'(uni_flits_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("prst_sel_red",   32'(sel_red_o),   32'd1);
        chk("prst_red_ready", 32'(red_ready_o), 32'd1);
        chk("prst_uni_ready", 32'(uni_ready_o), 32'd0);

        // 70000 reduction flits saturate the reduction statistic
        uni_valid_i = 1'b0;
        red_last_i  = 1'b1;
        #1;
        repeat (70000) tick();
        chk("sat_red_st", 32'(red_flits_o), es(32'h0000FFFF));
        chk("sat_uni_st", 32'(uni_flits_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
